// File: rtl/move_input_conditioner.sv
// Conditions four raw bouncing push-buttons into single-cycle move pulses for the game FSM.
// One press yields at most one pulse, released only while the consumer signals move_en.
module move_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 2500000,
    parameter int unsigned CNT_W           = 22
) (
    input  logic Clk,
    input  logic Reset,
    input  logic BtnU,
    input  logic BtnD,
    input  logic BtnL,
    input  logic BtnR,
    input  logic move_en,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic q_Idle,
    output logic q_Press,
    output logic q_Armed,
    output logic q_Held,
    output logic q_Release
);

    typedef enum logic [2:0] {StIdle, StPress, StArmed, StHeld, StRelease} state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       dir_q, dir_d;
    logic [3:0]       pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sel;

    // Bit order {U,D,L,R}; priority U > D > L > R matches the consumer's WAIT decode.
    always_comb begin
        sel = 4'b0000;
        if (sync2_q[3])      sel = 4'b1000;
        else if (sync2_q[2]) sel = 4'b0100;
        else if (sync2_q[1]) sel = 4'b0010;
        else if (sync2_q[0]) sel = 4'b0001;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            sync1_q <= '0;
            sync2_q <= '0;
            dir_q   <= '0;
            pulse_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= {BtnU, BtnD, BtnL, BtnR};
            sync2_q <= sync1_q;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        pulse_d = '0;
        case (state_q)
            StIdle: begin
                if (|sync2_q) begin
                    dir_d   = sel;
                    cnt_d   = '0;
                    state_d = StPress;
                end
            end
            StPress: begin
                if ((sync2_q & dir_q) == 4'b0000) state_d = StIdle;
                else if (cnt_q == CntMax)         state_d = StArmed;
                else                              cnt_d   = cnt_q + CNT_W'(1);
            end
            StArmed: begin
                // The move is committed; a release here does not cancel it.
                if (move_en) begin
                    pulse_d = dir_q;
                    state_d = StHeld;
                end
            end
            StHeld: begin
                if (sync2_q == 4'b0000) begin
                    cnt_d   = '0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (|sync2_q)             state_d = StHeld;
                else if (cnt_q == CntMax) state_d = StIdle;
                else                      cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        up        = pulse_q[3];
        down      = pulse_q[2];
        left      = pulse_q[1];
        right     = pulse_q[0];
        q_Idle    = (state_q == StIdle);
        q_Press   = (state_q == StPress);
        q_Armed   = (state_q == StArmed);
        q_Held    = (state_q == StHeld);
        q_Release = (state_q == StRelease);
    end

endmodule

// File: tb/tb_move_input_conditioner.sv
// Bench for move_input_conditioner: directed press scenarios plus random button/enable traffic,
// every cycle compared against a behavioural model of the press/release rules.
module tb_move_input_conditioner;

    localparam int D = 4;
    localparam int MIdle = 0, MPress = 1, MArmed = 2, MHeld = 3, MRelease = 4;

    logic Clk = 1'b0;
    logic Reset;
    logic BtnU, BtnD, BtnL, BtnR, move_en;
    logic up, down, left, right;
    logic q_Idle, q_Press, q_Armed, q_Held, q_Release;

    move_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .BtnU     (BtnU),
        .BtnD     (BtnD),
        .BtnL     (BtnL),
        .BtnR     (BtnR),
        .move_en  (move_en),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right),
        .q_Idle   (q_Idle),
        .q_Press  (q_Press),
        .q_Armed  (q_Armed),
        .q_Held   (q_Held),
        .q_Release(q_Release)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: buttons seen two edges late, mode, chosen button index (3=U..0=R), stable-run count.
    logic [3:0] m_s1, m_s2, m_pulse;
    int         m_mode, m_dir, m_run;

    // Per-scenario bookkeeping.
    int cyc, idle_idx, en_at;
    int pcnt[4];
    int pidx[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int top_index(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_pulse = '0;
        m_mode = MIdle; m_dir = 0; m_run = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic en);
        logic [3:0] seen;
        seen    = m_s2;
        m_pulse = '0;
        if (m_mode == MIdle) begin
            if (seen != 0) begin m_dir = top_index(seen); m_run = 1; m_mode = MPress; end
        end else if (m_mode == MPress) begin
            if (!seen[m_dir]) m_mode = MIdle;
            else if (m_run == D) m_mode = MArmed;
            else m_run++;
        end else if (m_mode == MArmed) begin
            if (en) begin m_pulse = 4'b0001 << m_dir; m_mode = MHeld; end
        end else if (m_mode == MHeld) begin
            if (seen == 0) begin m_run = 1; m_mode = MRelease; end
        end else begin
            if (seen != 0) m_mode = MHeld;
            else if (m_run == D) m_mode = MIdle;
            else m_run++;
        end
        m_s2 = m_s1;
        m_s1 = r;
    endtask

    task automatic new_scn();
        cyc = 0; idle_idx = -1;
        for (int i = 0; i < 4; i++) begin pcnt[i] = 0; pidx[i] = -1; end
    endtask

    task automatic cycle(input logic [3:0] r, input logic en);
        logic [3:0] outs;
        {BtnU, BtnD, BtnL, BtnR} = r;
        move_en = en;
        @(posedge Clk);
        model_step(r, en);
        #1;
        outs = {up, down, left, right};
        check("pulse", 32'(outs), 32'(m_pulse));
        check("state", 32'({q_Idle, q_Press, q_Armed, q_Held, q_Release}), 32'(5'b10000 >> m_mode));
        for (int i = 0; i < 4; i++) if (outs[i]) begin pcnt[i]++; pidx[i] = cyc; end
        if (q_Idle && idle_idx < 0) idle_idx = cyc;
        cyc++;
    endtask

    initial begin
        logic [3:0] r;
        int hold;
        Reset = 1'b1;
        {BtnU, BtnD, BtnL, BtnR} = 4'b0000;
        move_en = 1'b0;
        model_reset();
        #1;
        check("rst_state", 32'({q_Idle, q_Press, q_Armed, q_Held, q_Release}), 32'h10);
        check("rst_out", 32'({up, down, left, right}), 32'h0);
        @(negedge Clk);
        Reset = 1'b0;

        // Clean press held well past the debounce window.
        new_scn();
        repeat (20) cycle(4'b1000, 1'b1);
        check("s1_up_count", pcnt[3], 1);
        check("s1_up_edge", pidx[3], D + 3);
        check("s1_others", pcnt[0] + pcnt[1] + pcnt[2], 0);
        new_scn();
        repeat (12) cycle(4'b0000, 1'b1);
        check("s1_idle_edge", idle_idx, D + 2);

        // Bounces shorter than the window never produce a move.
        new_scn();
        repeat (3) begin
            repeat (2) cycle(4'b0010, 1'b1);
            repeat (4) cycle(4'b0000, 1'b1);
        end
        check("s2_no_pulse", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);
        check("s2_idle", q_Idle, 1);

        // Simultaneous down+right resolves to down only.
        new_scn();
        repeat (15) cycle(4'b0101, 1'b1);
        check("s3_down_count", pcnt[2], 1);
        check("s3_right_count", pcnt[0], 0);
        repeat (10) cycle(4'b0000, 1'b1);

        // Consumer not ready: move waits in ARMED across a release.
        new_scn();
        repeat (10) cycle(4'b0001, 1'b0);
        repeat (10) cycle(4'b0000, 1'b0);
        check("s4_armed", q_Armed, 1);
        check("s4_no_early", pcnt[0], 0);
        en_at = cyc;
        repeat (12) cycle(4'b0000, 1'b1);
        check("s4_right_count", pcnt[0], 1);
        check("s4_right_edge", pidx[0], en_at);
        check("s4_idle", q_Idle, 1);
        // A second button pressed while HELD is ignored.
        new_scn();
        repeat (10) cycle(4'b0100, 1'b1);
        repeat (8) cycle(4'b1100, 1'b1);
        check("s4_held_up", pcnt[3], 0);
        check("s4_held_down", pcnt[2], 1);
        repeat (10) cycle(4'b0000, 1'b1);
        check("s4_release_idle", q_Idle, 1);

        // Asynchronous reset while ARMED discards the pending move.
        new_scn();
        repeat (10) cycle(4'b1000, 1'b0);
        check("s5_armed", q_Armed, 1);
        #2 Reset = 1'b1;
        #1;
        check("s5_async_idle", q_Idle, 1);
        check("s5_async_armed", q_Armed, 0);
        check("s5_async_out", 32'({up, down, left, right}), 32'h0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        new_scn();
        repeat (12) cycle(4'b1000, 1'b1);
        check("s5_up_count", pcnt[3], 1);
        check("s5_up_edge", pidx[3], D + 3);
        repeat (10) cycle(4'b0000, 1'b1);

        // Random traffic: buttons held for random spans, enable toggling.
        r = 4'b0000;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                r    = ($urandom_range(0, 2) == 0) ? 4'(($urandom_range(0, 15))) : 4'b0000;
                hold = $urandom_range(1, 12);
            end
            hold--;
            cycle(r, ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
